// File: rtl/asm_pkg.sv
// Shared types, RV32I opcode/funct3 constants and encoding helpers for the serial text assembler.
package asm_pkg;

  localparam logic [7:0] TERM_CHAR_DEF      = 8'h0A;
  localparam int         MAX_IMM_DIGITS_DEF = 8;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SRL  = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_SW   = 3'd2;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_JALR = 3'd0;

  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_SH, CLS_S, CLS_B, CLS_J, CLS_U, CLS_NOP} op_class_e;
  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0, CAUSE_MNEM = 3'd1, CAUSE_SYNTAX = 3'd2, CAUSE_COUNT = 3'd3, CAUSE_RANGE = 3'd4
  } err_cause_e;
  typedef enum logic [1:0] {S_MNEM, S_OPND, S_SKIP, S_EMIT} state_e;
  typedef enum logic [1:0] {F_EMPTY, F_REG, F_IMM, F_IMMH} field_e;

  // {valid, value} for an ASCII hex digit of either case.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
    else if ((c >= "a" && c <= "f") || (c >= "A" && c <= "F")) return {1'b1, c[3:0] + 4'd9};
    else return 5'd0;
  endfunction

  function automatic logic [1:0] num_ops(input op_class_e cls);
    case (cls)
      CLS_J, CLS_U: return 2'd2;
      CLS_NOP:      return 2'd0;
      default:      return 2'd3;
    endcase
  endfunction

  // r0/r1/r2 are the register operands in the order they were typed.
  function automatic logic [31:0] encode(input op_class_e cls, input logic [6:0] opc,
                                         input logic [2:0] f3, input logic f7b5,
                                         input logic [4:0] r0, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [31:0] imm);
    logic [31:0] w;
    case (cls)
      CLS_R:   w = {1'b0, f7b5, 5'b0, r2, r1, f3, r0, opc};
      CLS_I:   w = {imm[11:0], r1, f3, r0, opc};
      CLS_SH:  w = {7'b0, imm[4:0], r1, f3, r0, opc};
      CLS_S:   w = {imm[11:5], r1, r0, f3, imm[4:0], opc};
      CLS_B:   w = {imm[12], imm[10:5], r1, r0, f3, imm[4:1], imm[11], opc};
      CLS_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], r0, opc};
      CLS_U:   w = {imm[19:0], r0, opc};
      default: w = {25'b0, opc};
    endcase
    return w;
  endfunction

  function automatic logic field_fits(input op_class_e cls, input logic [31:0] imm);
    case (cls)
      CLS_I, CLS_S: return imm[31:12] == '0;
      CLS_SH:       return imm[31:5] == '0;
      CLS_B:        return (imm[31:13] == '0) && !imm[0];
      CLS_J:        return (imm[31:21] == '0) && !imm[0];
      CLS_U:        return imm[31:20] == '0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/inst_assembler_if.sv
// Character-in / code-word-out bus of the text assembler, plus the error report.
interface inst_assembler_if;
  // Both channels are valid/ready: a beat transfers on a rising clock edge where
  // valid && ready; the sender holds valid and data stable until that edge.
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        code_valid;
  logic [31:0] code;
  logic        code_ready;
  logic        err;
  logic [2:0]  err_cause;

  modport master (output ch_valid, ch_data, code_ready,
                  input  ch_ready, code_valid, code, err, err_cause);
  modport slave  (input  ch_valid, ch_data, code_ready,
                  output ch_ready, code_valid, code, err, err_cause);
endinterface

// File: rtl/mnem_lookup.sv
// Combinational mnemonic decoder: right-aligned 5-character ASCII name to class/opcode/funct fields.
module mnem_lookup
  import asm_pkg::*;
(
  input  logic [39:0] mnem_i,
  output logic        hit_o,
  output op_class_e   cls_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o
);

  always_comb begin
    hit_o      = 1'b1;
    cls_o      = CLS_R;
    opcode_o   = OPC_OP;
    funct3_o   = F3_ADD;
    funct7b5_o = 1'b0;
    case (mnem_i)
      40'h0000616464: funct3_o = F3_ADD;                       // add
      40'h0000737562: funct7b5_o = 1'b1;                       // sub
      40'h0000616e64: funct3_o = F3_AND;
      40'h0000006f72: funct3_o = F3_OR;
      40'h0000736c74: funct3_o = F3_SLT;
      40'h00736c7475: funct3_o = F3_SLTU;
      40'h000073726c: funct3_o = F3_SRL;
      40'h0000786f72: funct3_o = F3_XOR;
      40'h0000736c6c: funct3_o = F3_SLL;
      40'h0000006c77: begin cls_o = CLS_I; opcode_o = OPC_LOAD;   funct3_o = F3_LW;   end
      40'h0000007377: begin cls_o = CLS_S; opcode_o = OPC_STORE;  funct3_o = F3_SW;   end
      40'h0000626571: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BEQ;  end
      40'h0000626e65: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BNE;  end
      40'h0000626c74: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BLT;  end
      40'h0000626765: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BGE;  end
      40'h00626c7475: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BLTU; end
      40'h0062676575: begin cls_o = CLS_B; opcode_o = OPC_BRANCH; funct3_o = F3_BGEU; end
      40'h00006a616c: begin cls_o = CLS_J; opcode_o = OPC_JAL; end
      40'h006a616c72: begin cls_o = CLS_I; opcode_o = OPC_JALR; funct3_o = F3_JALR; end
      40'h0061646469: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_ADD;  end
      40'h00616e6469: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_AND;  end
      40'h00006f7269: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_OR;   end
      40'h00736c7469: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_SLT;  end
      40'h736c746975: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_SLTU; end
      40'h0073726c69: begin cls_o = CLS_SH; opcode_o = OPC_OP_IMM; funct3_o = F3_SRL;  end
      40'h00736c6c69: begin cls_o = CLS_SH; opcode_o = OPC_OP_IMM; funct3_o = F3_SLL;  end
      40'h00786f7269: begin cls_o = CLS_I;  opcode_o = OPC_OP_IMM; funct3_o = F3_XOR;  end
      40'h00006c7569: begin cls_o = CLS_U;  opcode_o = OPC_LUI; end
      40'h00006e6f70: begin cls_o = CLS_NOP; opcode_o = OPC_OP_IMM; end
      default:        hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_assembler.sv
// Serial RV32I text assembler: one ASCII character in per beat, one machine word out per line.
// Build option IMM_RANGE_CHECK_EN rejects immediates that do not fit their field (cause 4).
module inst_assembler
  import asm_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR      = TERM_CHAR_DEF,
  parameter int         MAX_IMM_DIGITS = MAX_IMM_DIGITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_assembler_if.slave bus,
  output state_e          state_o
);

  state_e          state_q, state_d;
  logic [39:0]     mnem_q, mnem_d;
  logic [2:0]      mcnt_q, mcnt_d;
  op_class_e       cls_q, cls_d;
  logic [6:0]      opc_q, opc_d;
  logic [2:0]      f3_q, f3_d;
  logic            f7_q, f7_d;
  logic [1:0]      opn_q, opn_d;
  field_e          fkind_q, fkind_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [2:0][4:0] regs_q, regs_d;
  logic [31:0]     acc_q, acc_d;
  err_cause_e      pend_q, pend_d;
  logic [31:0]     code_q, code_d;
  logic            err_q, err_d;
  err_cause_e      errc_q, errc_d;

  logic            lk_hit, lk_f7;
  op_class_e       lk_cls;
  logic [6:0]      lk_opc;
  logic [2:0]      lk_f3;

  logic            ch_ready, fire, is_term, want_imm, fail_v;
  logic [7:0]      ch;
  logic [4:0]      hx;
  logic [8:0]      reg_new;
  logic [1:0]      n_ops, given;
  err_cause_e      fail_c;

  mnem_lookup u_lookup (
    .mnem_i    (mnem_q),
    .hit_o     (lk_hit),
    .cls_o     (lk_cls),
    .opcode_o  (lk_opc),
    .funct3_o  (lk_f3),
    .funct7b5_o(lk_f7)
  );

  assign ch       = bus.ch_data;
  assign ch_ready = (state_q != S_EMIT);
  assign fire     = bus.ch_valid && ch_ready;
  assign is_term  = (ch == TERM_CHAR) || (ch == ";");
  assign hx       = hex_dec(ch);
  assign reg_new  = {regs_q[opn_q], hx[3:0]};
  assign n_ops    = num_ops(cls_q);
  assign given    = opn_q + 2'(fkind_q != F_EMPTY);
  // Only the last operand of a non-R instruction is an immediate.
  assign want_imm = (cls_q != CLS_R) && (opn_q == n_ops - 2'd1);

  always_comb begin
    state_d = state_q;  mnem_d = mnem_q;   mcnt_d = mcnt_q;
    cls_d   = cls_q;    opc_d  = opc_q;    f3_d   = f3_q;     f7_d = f7_q;
    opn_d   = opn_q;    fkind_d = fkind_q; dcnt_d = dcnt_q;
    regs_d  = regs_q;   acc_d  = acc_q;    pend_d = pend_q;   code_d = code_q;
    err_d   = 1'b0;     errc_d = errc_q;
    fail_v  = 1'b0;     fail_c = CAUSE_SYNTAX;
    case (state_q)
      S_MNEM: if (fire) begin
        if (ch >= "a" && ch <= "z") begin
          if (mcnt_q == 3'd5) begin fail_v = 1'b1; fail_c = CAUSE_MNEM; end
          else begin mnem_d = {mnem_q[31:0], ch}; mcnt_d = mcnt_q + 3'd1; end
        end else if (ch == " " || is_term) begin
          if (mcnt_q != 3'd0) begin
            if (!lk_hit) begin fail_v = 1'b1; fail_c = CAUSE_MNEM; end
            else if (!is_term) begin
              cls_d = lk_cls; opc_d = lk_opc; f3_d = lk_f3; f7_d = lk_f7;
              state_d = S_OPND;
            end else if (num_ops(lk_cls) != 2'd0) begin fail_v = 1'b1; fail_c = CAUSE_COUNT; end
            else begin
              code_d  = encode(lk_cls, lk_opc, lk_f3, lk_f7, 5'd0, 5'd0, 5'd0, 32'd0);
              state_d = S_EMIT;
            end
          end
        end else fail_v = 1'b1;
      end
      S_OPND: if (fire && ch != " ") begin
        if (is_term) begin
          if (given != n_ops) begin fail_v = 1'b1; fail_c = CAUSE_COUNT; end
          else if (fkind_q == F_REG && dcnt_q == 4'd0) fail_v = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
          else if (!field_fits(cls_q, acc_q)) begin fail_v = 1'b1; fail_c = CAUSE_RANGE; end
`endif
          else begin
            code_d  = encode(cls_q, opc_q, f3_q, f7_q, regs_q[0], regs_q[1], regs_q[2], acc_q);
            state_d = S_EMIT;
          end
        end else if (ch == ",") begin
          if (fkind_q == F_EMPTY || (fkind_q == F_REG && dcnt_q == 4'd0)) fail_v = 1'b1;
          else if (opn_q + 2'd1 >= n_ops) begin fail_v = 1'b1; fail_c = CAUSE_COUNT; end
          else begin opn_d = opn_q + 2'd1; fkind_d = F_EMPTY; dcnt_d = 4'd0; end
        end else if (fkind_q == F_EMPTY) begin
          if (opn_q >= n_ops) begin fail_v = 1'b1; fail_c = CAUSE_COUNT; end
          else if (ch == "x" && !want_imm) fkind_d = F_REG;
          else if (hx[4] && want_imm) begin
            fkind_d = F_IMM; acc_d = {28'd0, hx[3:0]}; dcnt_d = 4'd1;
          end else fail_v = 1'b1;
        end else if (fkind_q == F_REG) begin
          if (hx[4] && dcnt_q < 4'd2 && reg_new <= 9'd31) begin
            regs_d[opn_q] = reg_new[4:0]; dcnt_d = dcnt_q + 4'd1;
          end else fail_v = 1'b1;
        end else if (fkind_q == F_IMM) begin
          if (hx[4] && 32'(dcnt_q) < MAX_IMM_DIGITS) begin
            acc_d = {acc_q[27:0], hx[3:0]}; dcnt_d = dcnt_q + 4'd1;
          end else if (ch == "H" || ch == "h") fkind_d = F_IMMH;
          else fail_v = 1'b1;
        end else fail_v = 1'b1;
      end
      S_SKIP: if (fire && is_term) begin
        err_d = 1'b1; errc_d = pend_q; state_d = S_MNEM;
      end
      S_EMIT: if (bus.code_ready) state_d = S_MNEM;
      default: state_d = S_MNEM;
    endcase
    // An error found on the terminator itself is reported at once instead of via S_SKIP.
    if (fail_v) begin
      if (is_term) begin err_d = 1'b1; errc_d = fail_c; state_d = S_MNEM; end
      else begin pend_d = fail_c; state_d = S_SKIP; end
    end
    if (fire && is_term) begin
      mnem_d = '0; mcnt_d = '0; opn_d = '0; fkind_d = F_EMPTY;
      dcnt_d = '0; regs_d = '0; acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_MNEM;  mnem_q <= '0;   mcnt_q <= '0;
      cls_q   <= CLS_R;   opc_q  <= '0;   f3_q   <= '0;   f7_q <= 1'b0;
      opn_q   <= '0;      fkind_q <= F_EMPTY; dcnt_q <= '0;
      regs_q  <= '0;      acc_q  <= '0;   pend_q <= CAUSE_NONE;
      code_q  <= '0;      err_q  <= 1'b0; errc_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d; mnem_q <= mnem_d; mcnt_q <= mcnt_d;
      cls_q   <= cls_d;   opc_q  <= opc_d;  f3_q   <= f3_d;   f7_q <= f7_d;
      opn_q   <= opn_d;   fkind_q <= fkind_d; dcnt_q <= dcnt_d;
      regs_q  <= regs_d;  acc_q  <= acc_d;  pend_q <= pend_d;
      code_q  <= code_d;  err_q  <= err_d;  errc_q <= errc_d;
    end
  end

  assign bus.ch_ready   = ch_ready;
  assign bus.code_valid = (state_q == S_EMIT);
  assign bus.code       = code_q;
  assign bus.err        = err_q;
  assign bus.err_cause  = errc_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Directed bench for inst_assembler: typed lines against hand-assembled RV32I words and error causes.
module tb_inst_assembler;
  import asm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  state_e      dbg_state;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  inst_assembler_if bus();

  inst_assembler dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_char(input logic [7:0] c);
    int waited = 0;
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    while (bus.ch_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.ch_ready !== 1'b1) check("ch_ready_timeout", 32'(bus.ch_ready), 32'd1);
    @(posedge clk); #1;
    bus.ch_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic pop_code(input string tag);
    bus.code_ready = 1'b1;
    @(posedge clk); #1;
    bus.code_ready = 1'b0;
    check({tag, "_drained"}, 32'(bus.code_valid), 32'd0);
  endtask

  task automatic line_code(input string body, input logic [7:0] term, input logic [31:0] exp,
                           input string tag, input bit drain);
    exp_q.push_back(exp);
    send_str(body);
    check({tag, "_early"}, 32'(bus.code_valid), 32'd0);
    send_char(term);
    check({tag, "_valid"}, 32'(bus.code_valid), 32'd1);
    check({tag, "_code"}, bus.code, exp_q.pop_front());
    if (drain) pop_code(tag);
  endtask

  task automatic line_err(input string body, input logic [2:0] cause, input string tag);
    send_str(body);
    send_char(8'h0A);
    check({tag, "_err"}, 32'(bus.err), 32'd1);
    check({tag, "_cause"}, 32'(bus.err_cause), 32'(cause));
    check({tag, "_nocode"}, 32'(bus.code_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    bus.ch_valid   = 1'b0;
    bus.ch_data    = 8'h00;
    bus.code_ready = 1'b0;
    #2;
    check("rst_code_valid", 32'(bus.code_valid), 32'd0);
    check("rst_code", bus.code, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_cause", 32'(bus.err_cause), 32'd0);
    check("rst_ch_ready", 32'(bus.ch_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_MNEM));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    line_code("addi x01,x00,005H", 8'h0A, 32'h00500093, "addi", 1'b1);
    line_code("sub x03,x01,x02",   8'h0A, 32'h402081B3, "sub",  1'b1);
    line_code("beq x01,x02,0008",  8'h0A, 32'h00208463, "beq",  1'b1);
    line_code("jal x01,000010H",   8'h0A, 32'h010000EF, "jal",  1'b1);
    line_code("lui x05,12345H",    8'h0A, 32'h123452B7, "lui",  1'b1);
    line_code("sw x02,x03,010",    ";",   32'h00312823, "sw_semi", 1'b1);
    line_code("slli x01,x01,1F",   8'h0A, 32'h01F09093, "slli", 1'b1);
    line_code(" add x1F, x1F ,x1F", 8'h0A, 32'h01FF8FB3, "add_x31", 1'b1);

    line_err("addi x01,x00,000000001", 3'd2, "imm_9dig");
    line_err("foo x01", 3'd1, "unknown");
    line_err("add x01,x02", 3'd3, "too_few");
    line_err("add x01,x40,x02", 3'd2, "reg_big");
    line_code("nop", 8'h0A, 32'h00000013, "nop", 1'b1);
    check("cause_held", 32'(bus.err_cause), 32'd2);

    send_char(8'h0A);
    check("empty_err", 32'(bus.err), 32'd0);
    check("empty_code", 32'(bus.code_valid), 32'd0);
    check("empty_state", 32'(dbg_state), 32'(S_MNEM));

    // backpressure: word held, characters stalled
    line_code("or x01,x02,x03", 8'h0A, 32'h003160B3, "bp", 1'b0);
    bus.ch_valid = 1'b1;
    bus.ch_data  = "a";
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_ch_ready", 32'(bus.ch_ready), 32'd0);
      check("bp_valid", 32'(bus.code_valid), 32'd1);
      check("bp_stable", bus.code, 32'h003160B3);
    end
    bus.ch_valid = 1'b0;
    pop_code("bp");
    check("bp_ready_back", 32'(bus.ch_ready), 32'd1);

    // reset in the middle of a line
    send_str("add x0");
    rst_n = 1'b0;
    #2;
    check("mid_rst_code", bus.code, 32'd0);
    check("mid_rst_valid", 32'(bus.code_valid), 32'd0);
    check("mid_rst_cause", 32'(bus.err_cause), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_MNEM));
    @(posedge clk); #1;
    rst_n = 1'b1;
    line_code("xori x02,x03,0FFH", 8'h0A, 32'h0FF1C113, "after_rst", 1'b1);

`ifdef IMM_RANGE_CHECK_EN
    line_err("addi x01,x00,1000H", 3'd4, "range");
`else
    line_code("addi x01,x00,1000H", 8'h0A, 32'h00000093, "trunc", 1'b1);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
